bcd_to_bin: RTL
===============

# bcd_to_bin

Sequential BCD-to-binary converter using the reverse double-dabble algorithm: shift right, then subtract 3 from every BCD digit that is 8 or more. It is the decode-direction counterpart of the add-3 binary-to-BCD path. It sits between the decimal entry or display-side logic and binary arithmetic, and converts one packed-BCD word per start/done transaction.

## Interface

Parameters:
- `DIGITS`, 3, number of packed BCD input digits.
- `WIDTH`, 10, binary output width. Must satisfy 10^DIGITS − 1 < 2^WIDTH.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  request a conversion. Ignored while `busy`=1.
- `bcd`  in  4*DIGITS  packed BCD; digit 0 is in [3:0]. Sampled only at the accept edge.
- `busy`  out  1  conversion in progress.
- `done`  out  1  one-cycle pulse; `bin` and `err` are valid in that cycle.
- `bin`  out  WIDTH  binary result. Held until the next accept.
- `err`  out  1  an input digit was greater than 9. Held with `bin`.

## Operation

- Reset values: `busy`=0, `done`=0, `bin`=0, `err`=0, state IDLE, iteration counter 0.
- The FSM has two states, IDLE and RUN.
- **IDLE:** if `start`=1 at a rising edge, the block accepts the request.
  - Loads the work register {bcd, WIDTH'b0}, which is 4*DIGITS+WIDTH bits.
  - Latches `err_r` = OR over all digits of (digit > 9).
  - Clears the counter and moves to RUN.
- **RUN:** each cycle does one iteration.
  - Logical shift right of the whole work register by 1. The BCD LSB enters the binary MSB.
  - Then, in the same cycle, each 4-bit BCD field with value ≥ 8 has 3 subtracted (combinational, after the shift).
  - The counter increments.
  - After iteration WIDTH the state returns to IDLE.
  - On that transition: `bin` ← low WIDTH bits of the work register (forced to 0 if `err_r`=1), `err` ← `err_r`, `done` ← 1 for one cycle.
- An invalid digit does not shorten latency; the conversion runs its full length.
- `start` while in RUN is dropped. It is not queued.
- Each digit's subtract-3 is 4-bit unsigned. Valid BCD never underflows.

## Timing

- `start` sampled high at edge k (IDLE) → `busy`=1 after edge k.
- `done`=1 and `bin`/`err` update after edge k+WIDTH; `busy` falls at the same edge. Latency is WIDTH cycles from accept to result; 10 with defaults.
- Back-to-back operation: `start`=1 in the cycle where `done`=1 is accepted, because `busy`=0 in that cycle. Throughput is one conversion per WIDTH+1 cycles.
- `bin`/`err` are stable from the `done` cycle until the next `done` or reset.
- Reset mid-conversion: at the next edge, all outputs return to reset values, the work register is discarded and no `done` is issued.
- `rst` and `start` high together: `rst` wins and nothing is accepted.

## Structure

- Shared package `bcd_pkg` holds:
  - `BCD_DIGIT_W`=4.
  - Correction constants `BCD_SUB_THRESH`=8 and `BCD_SUB_VAL`=3.
  - State enum `bcd_conv_state_t` {IDLE, RUN}.
  - The same digit-width constant is reused by the binary-to-BCD path.
- Sub-module `sub3_digit`: combinational 4-bit cell, out = (in ≥ 8) ? in − 3 : in. It is instantiated DIGITS times via generate and mirrors the existing add-3 cell.
- The top level holds the FSM, the counter ($clog2(WIDTH+1) bits), the work register and the output registers.

## Test plan

- Reset, then `bcd`=12'h000 with `start` pulse → after 10 cycles `done`=1, `bin`=0, `err`=0; `busy` high for exactly 10 cycles.
- `bcd`=12'h255 → `bin`=10'd255 (0x0FF), `err`=0, `done` exactly 10 cycles after the accept edge.
- `bcd`=12'h999 → `bin`=10'd999 (0x3E7). Then, in the `done` cycle, `start` with 12'h001 → accepted; next `done` 10 cycles later with `bin`=1.
- `bcd`=12'h1A3 → after 10 cycles `done`=1, `err`=1, `bin`=0. A following 12'h042 → `err`=0, `bin`=42.
- `start` with 12'h123, then `start` with 12'h777 on cycle 3 of RUN → second request ignored; single `done` with `bin`=123.
- `start` with 12'h500, then `rst`=1 on cycle 5 → next edge `busy`=0, `done`=0, `bin`=0, `err`=0; no `done` afterwards. A fresh 12'h500 → `bin`=500.

Source files
------------

// File: rtl/bcd_pkg.sv
// ============================================================================
// Module      : bcd_pkg
// Description : Shared BCD constants and converter state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

    localparam int          BCD_DIGIT_W    = 4;
    localparam logic [3:0]  BCD_SUB_THRESH = 4'd8;
    localparam logic [3:0]  BCD_SUB_VAL    = 4'd3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } bcd_conv_state_t;

endpackage

`default_nettype wire

// File: rtl/sub3_digit.sv
// ============================================================================
// Module      : sub3_digit
// Description : Reverse double-dabble correction cell: subtract 3 when >= 8.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sub3_digit
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] i_digit,
    output logic [BCD_DIGIT_W-1:0] o_digit
);

    assign o_digit = (i_digit >= BCD_SUB_THRESH) ? (i_digit - BCD_SUB_VAL) : i_digit;

endmodule

`default_nettype wire

// File: rtl/bcd_to_bin.sv
// ============================================================================
// Module      : bcd_to_bin
// Description : Sequential packed-BCD to binary converter (shift right, sub 3).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_to_bin
    import bcd_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int WIDTH  = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
    output logic                          busy,
    output logic                          done,
    output logic [WIDTH-1:0]              bin,
    output logic                          err
);

    localparam int c_bcd_w  = BCD_DIGIT_W * DIGITS;
    localparam int c_work_w = c_bcd_w + WIDTH;
    localparam int c_cnt_w  = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_last_iter = c_cnt_w'(WIDTH - 1);

    bcd_conv_state_t      r_state;
    bcd_conv_state_t      w_state_next;
    logic [c_work_w-1:0]  r_work;
    logic [c_work_w-1:0]  w_shift;
    logic [c_work_w-1:0]  w_next;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [DIGITS-1:0]    w_digit_bad;
    logic                 r_err_lat;
    logic                 r_done;
    logic [WIDTH-1:0]     r_bin;
    logic                 r_err;
    logic                 w_accept;
    logic                 w_last;

    assign w_accept = (r_state == IDLE) && start;
    assign w_last   = (r_state == RUN) && (r_cnt == c_last_iter);

    // Correction applies to the BCD fields only, after the shift.
    assign w_shift = r_work >> 1;
    assign w_next[WIDTH-1:0] = w_shift[WIDTH-1:0];

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        sub3_digit u_sub3 (
            .i_digit (w_shift[WIDTH + BCD_DIGIT_W*gi +: BCD_DIGIT_W]),
            .o_digit (w_next [WIDTH + BCD_DIGIT_W*gi +: BCD_DIGIT_W])
        );
        assign w_digit_bad[gi] = (bcd[BCD_DIGIT_W*gi +: BCD_DIGIT_W] > 4'd9);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start)  w_state_next = RUN;
            RUN:     if (w_last) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == RUN);
        done = r_done;
        bin  = r_bin;
        err  = r_err;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_work    <= '0;
            r_cnt     <= '0;
            r_err_lat <= 1'b0;
            r_done    <= 1'b0;
            r_bin     <= '0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_work    <= {bcd, {WIDTH{1'b0}}};
                r_err_lat <= |w_digit_bad;
                r_cnt     <= '0;
            end else if (r_state == RUN) begin
                r_work <= w_next;
                r_cnt  <= r_cnt + 1'b1;
                if (w_last) begin
                    r_done <= 1'b1;
                    r_bin  <= r_err_lat ? '0 : w_next[WIDTH-1:0];
                    r_err  <= r_err_lat;
                end
            end
        end
    end

endmodule

`default_nettype wire
